// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: four one-byte holding registers shared
// round-robin onto a single UART transmitter write port.
module uart_tx_arbiter #(
   parameter int unsigned BUSY_TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_data,
   output logic [3:0]  req_ready,
   output logic        tx_wr,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   output logic [1:0]  grant_id,
   output logic        active,
   output logic        timeout_err,
   input  logic        clr_err
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE
   } state_t;

   localparam logic [15:0] CNT_LAST = 16'(BUSY_TIMEOUT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  full;
   logic [7:0]  hold [4];
   logic [1:0]  last_grant;
   logic [15:0] cnt;
   logic [1:0]  win;
   logic        found;
   logic        load;
   logic        time_out;

   // first full channel after the previous winner, wrapping
   always_comb begin
      win   = last_grant;
      found = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         if (!found && full[last_grant + 2'(j)]) begin
            win   = last_grant + 2'(j);
            found = 1'b1;
         end
      end
   end

   assign load     = (state == IDLE) && found && !tx_busy;
   assign time_out = (state == ISSUE) && !tx_busy
                   && (cnt == CNT_LAST);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (load) state_nxt = ISSUE;
         end
         ISSUE: begin
            if (tx_busy)       state_nxt = WAIT_DONE;
            else if (time_out) state_nxt = IDLE;
         end
         WAIT_DONE: begin
            if (!tx_busy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         tx_wr       <= 1'b0;
         tx_data     <= 8'h00;
         grant_id    <= 2'd0;
         last_grant  <= 2'd3;
         cnt         <= 16'd0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nxt;
         tx_wr <= (state_nxt == ISSUE);
         if (load) begin
            tx_data    <= hold[win];
            grant_id   <= win;
            last_grant <= win;
            cnt        <= 16'd0;
         end else if (state == ISSUE) begin
            cnt <= cnt + 16'd1;
         end
         // a timeout in the same cycle as a clear must stay visible
         if (time_out)     timeout_err <= 1'b1;
         else if (clr_err) timeout_err <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full <= 4'b0000;
         for (int i = 0; i < 4; i++) hold[i] <= 8'h00;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (load && (win == 2'(i))) begin
               full[i] <= 1'b0;
            end else if (req_valid[i] && !full[i]) begin
               full[i] <= 1'b1;
               hold[i] <= req_data[8*i +: 8];
            end
         end
      end
   end

   assign req_ready = ~full;
   assign active    = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors plus hand sequences
// for the four-channel UART transmit arbiter.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_wr;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        active;
   logic        timeout_err;
   logic        clr_err;

   logic        model_on;
   logic        ext_busy;
   logic        mb;
   logic [1:0]  wc;
   logic [4:0]  bc;
   logic        prev_wr;
   logic [9:0]  log_q [$];

   int total;
   int passed;

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic        busy;
      logic [3:0]  ready;
      logic        wr;
      logic [7:0]  txd;
      logic [1:0]  gid;
      logic        act;
   } vec_t;

   vec_t tbl [14];

   uart_tx_arbiter #(.BUSY_TIMEOUT(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_wr       (tx_wr),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .grant_id    (grant_id),
      .active      (active),
      .timeout_err (timeout_err),
      .clr_err     (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign tx_busy = mb | ext_busy;

   // transmitter: busy 3 edges after wr is seen, held 20 cycles
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mb <= 1'b0;
         wc <= 2'd0;
         bc <= 5'd0;
      end else if (!model_on) begin
         mb <= 1'b0;
         wc <= 2'd0;
      end else if (mb) begin
         if (bc == 5'd1) mb <= 1'b0;
         bc <= bc - 5'd1;
      end else if (tx_wr) begin
         if (wc == 2'd2) begin
            mb <= 1'b1;
            bc <= 5'd20;
            wc <= 2'd0;
         end else begin
            wc <= wc + 2'd1;
         end
      end else begin
         wc <= 2'd0;
      end
   end

   always @(negedge clk) begin
      if (tx_wr && !prev_wr) log_q.push_back({grant_id, tx_data});
      prev_wr <= tx_wr;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         passed++;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      repeat (2) tick;
      reset = 1'b1;
      tick;
   endtask

   task automatic wait_log(input int n);
      for (int i = 0; i < 600 && log_q.size() < n; i++) tick;
      chk($sformatf("wait_log%0d", n), 64'(log_q.size() >= n), 1);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 200 && active; i++) tick;
      chk(name, active, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [9:0] exp_log [6];
      total     = 0;
      passed    = 0;
      reset     = 1'b0;
      req_valid = 4'b0;
      req_data  = 32'h0;
      clr_err   = 1'b0;
      model_on  = 1'b0;
      ext_busy  = 1'b0;
      prev_wr   = 1'b0;

      tbl[0]  = '{4'b0000, 32'h0, 1'b1, 4'b1111, 1'b0, 8'h00, 2'd0, 1'b0};
      tbl[1]  = '{4'b1000, 32'hC3000000, 1'b1,
                  4'b0111, 1'b0, 8'h00, 2'd0, 1'b0};
      tbl[2]  = '{4'b0000, 32'h0, 1'b1, 4'b0111, 1'b0, 8'h00, 2'd0, 1'b0};
      tbl[3]  = '{4'b0000, 32'h0, 1'b0, 4'b1111, 1'b1, 8'hC3, 2'd3, 1'b1};
      tbl[4]  = '{4'b0001, 32'h5A, 1'b1, 4'b1110, 1'b0, 8'hC3, 2'd3, 1'b1};
      tbl[5]  = '{4'b0001, 32'h77, 1'b1, 4'b1110, 1'b0, 8'hC3, 2'd3, 1'b1};
      tbl[6]  = '{4'b0001, 32'h77, 1'b0, 4'b1110, 1'b0, 8'hC3, 2'd3, 1'b0};
      tbl[7]  = '{4'b0001, 32'h77, 1'b0, 4'b1111, 1'b1, 8'h5A, 2'd0, 1'b1};
      tbl[8]  = '{4'b0001, 32'h77, 1'b0, 4'b1110, 1'b1, 8'h5A, 2'd0, 1'b1};
      tbl[9]  = '{4'b0000, 32'h0, 1'b1, 4'b1110, 1'b0, 8'h5A, 2'd0, 1'b1};
      tbl[10] = '{4'b0000, 32'h0, 1'b0, 4'b1110, 1'b0, 8'h5A, 2'd0, 1'b0};
      tbl[11] = '{4'b0000, 32'h0, 1'b0, 4'b1111, 1'b1, 8'h77, 2'd0, 1'b1};
      tbl[12] = '{4'b0000, 32'h0, 1'b1, 4'b1111, 1'b0, 8'h77, 2'd0, 1'b1};
      tbl[13] = '{4'b0000, 32'h0, 1'b0, 4'b1111, 1'b0, 8'h77, 2'd0, 1'b0};

      exp_log[0] = {2'd0, 8'h10};
      exp_log[1] = {2'd1, 8'h11};
      exp_log[2] = {2'd2, 8'h12};
      exp_log[3] = {2'd3, 8'h13};
      exp_log[4] = {2'd0, 8'h20};
      exp_log[5] = {2'd1, 8'h21};

      #3;
      chk("reset_async",
          {req_ready, tx_wr, tx_data, grant_id, active, timeout_err},
          {4'b1111, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0});
      do_reset;

      // single byte on ch2
      model_on  = 1'b1;
      req_valid = 4'b0100;
      req_data  = 32'h00A50000;
      tick;
      chk("sb_accept", {req_ready[2], tx_wr}, {1'b0, 1'b0});
      req_valid = 4'b0000;
      tick;
      chk("sb_issue", {tx_wr, tx_data, grant_id, req_ready[2]},
          {1'b1, 8'hA5, 2'd2, 1'b1});
      n = 1;
      for (int i = 0; i < 50; i++) begin
         tick;
         if (!tx_wr) break;
         n++;
      end
      chk("sb_wr_cycles", n, 4);
      chk("sb_busy_drop", {tx_busy, active, tx_data}, {1'b1, 1'b1, 8'hA5});

      // reset in WAIT_DONE with ch1 holding a byte
      req_valid = 4'b0010;
      req_data  = 32'h00009900;
      tick;
      req_valid = 4'b0000;
      tick;
      chk("wd_before_rst", {active, tx_wr, req_ready}, {1'b1, 1'b0, 4'b1101});
      #2;
      reset = 1'b0;
      #1;
      chk("midop_reset",
          {req_ready, tx_wr, tx_data, grant_id, active, timeout_err},
          {4'b1111, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0});
      tick;
      tick;
      reset = 1'b1;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         tick;
         if (tx_wr) n++;
      end
      chk("midop_no_wr", n, 0);

      // round robin with reloads
      log_q.delete();
      req_valid = 4'b1111;
      req_data  = 32'h13121110;
      tick;
      req_valid = 4'b0000;
      wait_log(3);
      req_valid = 4'b0001;
      req_data  = 32'h00000020;
      tick;
      req_valid = 4'b0000;
      wait_log(4);
      req_valid = 4'b0010;
      req_data  = 32'h00002100;
      tick;
      req_valid = 4'b0000;
      wait_log(6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("rr_order%0d", i),
             (i < log_q.size()) ? log_q[i] : 10'h3FF, exp_log[i]);
      wait_idle("rr_idle");
      model_on = 1'b0;
      tick;

      // timeout on ch1, transmitter never busy
      req_valid = 4'b0010;
      req_data  = 32'h00003C00;
      tick;
      req_valid = 4'b0000;
      tick;
      chk("to_issue", {tx_wr, tx_data, grant_id}, {1'b1, 8'h3C, 2'd1});
      n = 1;
      for (int i = 0; i < 100; i++) begin
         tick;
         if (!tx_wr) break;
         n++;
      end
      chk("to_wr_cycles", n, 8);
      chk("to_err_idle", {timeout_err, active}, {1'b1, 1'b0});
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (tx_wr) n++;
      end
      chk("to_no_retry", n, 0);
      clr_err = 1'b1;
      tick;
      clr_err = 1'b0;
      chk("to_clr", timeout_err, 0);

      // timeout while clr_err held: set wins, then clears
      clr_err   = 1'b1;
      req_valid = 4'b0100;
      req_data  = 32'h00440000;
      tick;
      req_valid = 4'b0000;
      tick;
      n = 1;
      for (int i = 0; i < 100; i++) begin
         tick;
         if (!tx_wr) break;
         n++;
      end
      chk("sw_wr_cycles", n, 8);
      chk("sw_set_wins", timeout_err, 1);
      tick;
      chk("sw_clr_after", timeout_err, 0);
      clr_err = 1'b0;

      // external busy and back-pressure vectors
      do_reset;
      for (int i = 0; i < 14; i++) begin
         req_valid = tbl[i].valid;
         req_data  = tbl[i].data;
         ext_busy  = tbl[i].busy;
         tick;
         chk($sformatf("vec%0d", i),
             {req_ready, tx_wr, tx_data, grant_id, active},
             {tbl[i].ready, tbl[i].wr, tbl[i].txd, tbl[i].gid, tbl[i].act});
      end
      req_valid = 4'b0000;
      ext_busy  = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
